// File: rtl/exe_div_unit_pkg.sv
// rtl/exe_div_unit_pkg.sv - shared constants and state type for the EXE-stage divider
package exe_div_unit_pkg;

   localparam int DIV_XLEN  = 32;
   localparam int DIV_CNT_W = 6;

   localparam logic [2:0] DIV_F3  = 3'b100;
   localparam logic [2:0] DIVU_F3 = 3'b101;
   localparam logic [2:0] REM_F3  = 3'b110;
   localparam logic [2:0] REMU_F3 = 3'b111;

   localparam logic [6:0] MULDIV_F7 = 7'b0000001;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;

endpackage

// File: rtl/exe_div_unit_if.sv
// rtl/exe_div_unit_if.sv - EX-stage divide request/response bundle
interface exe_div_unit_if;
   import exe_div_unit_pkg::*;

   logic                start;
   logic [2:0]          funct3;
   logic [DIV_XLEN-1:0] rs1_data;
   logic [DIV_XLEN-1:0] rs2_data;
   logic [5:0]          rd_addr;
   logic                flush;
   logic                stall;
   logic                done;
   logic [DIV_XLEN-1:0] result;
   logic [5:0]          rd_addr_out;

   modport master (
      output start, funct3, rs1_data, rs2_data, rd_addr, flush,
      input  stall, done, result, rd_addr_out
   );

   modport slave (
      input  start, funct3, rs1_data, rs2_data, rd_addr, flush,
      output stall, done, result, rd_addr_out
   );

endinterface

// File: rtl/exe_div_unit.sv
// rtl/exe_div_unit.sv - iterative RV32M restoring divide/remainder unit with pipeline stall
module exe_div_unit
   import exe_div_unit_pkg::*;
#(
   parameter int XLEN  = DIV_XLEN,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic           clk,
   input  logic           rst,
   exe_div_unit_if.slave  div_if
);

   function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
      return x[XLEN-1] ? -x : x;
   endfunction

   function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] x);
      return neg ? -x : x;
   endfunction

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   // Restoring keeps R below the divisor, so the 33rd bit exists only in the trial term.
   logic [XLEN-1:0]  rem_q;
   logic [XLEN-1:0]  quo_q;
   logic [XLEN-1:0]  dvs_q;
   logic [2:0]       f3_q;
   logic [5:0]       rd_q;
   logic             neg_q_q;
   logic             neg_r_q;
   logic [XLEN-1:0]  result_q;
   logic [5:0]       rd_out_q;

   logic             is_signed, is_rem, start_ok, div_zero, overflow, fast_path;
   logic [XLEN-1:0]  special_res;
   logic [XLEN:0]    shifted, trial;
   logic [XLEN-1:0]  step_rem, step_quo, final_res;
   logic             last_step, rem_op_q;

   always_comb begin
      is_signed   = (div_if.funct3 == DIV_F3) || (div_if.funct3 == REM_F3);
      is_rem      = (div_if.funct3 == REM_F3) || (div_if.funct3 == REMU_F3);
      start_ok    = (state_q == IDLE) && div_if.start && !div_if.flush;
      div_zero    = (div_if.rs2_data == '0);
      overflow    = is_signed && (div_if.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                    && (div_if.rs2_data == '1);
      fast_path   = div_zero || overflow;
      special_res = '0;
      if (div_zero)
         special_res = is_rem ? div_if.rs1_data : '1;
      else if (!is_rem)
         special_res = {1'b1, {(XLEN-1){1'b0}}};
   end

   always_comb begin
      shifted   = {rem_q, quo_q[XLEN-1]};
      trial     = shifted - {1'b0, dvs_q};
      step_rem  = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
      step_quo  = {quo_q[XLEN-2:0], ~trial[XLEN]};
      rem_op_q  = (f3_q == REM_F3) || (f3_q == REMU_F3);
      final_res = rem_op_q ? neg_if(neg_r_q, step_rem) : neg_if(neg_q_q, step_quo);
      last_step = (cnt_q == CNT_W'(XLEN-1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = fast_path ? DONE : CALC;
         CALC:    if (last_step) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (div_if.flush)
         state_d = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         f3_q     <= '0;
         rd_q     <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
      end else if (start_ok) begin
         f3_q    <= div_if.funct3;
         rd_q    <= div_if.rd_addr;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= is_signed ? abs_val(div_if.rs1_data) : div_if.rs1_data;
         dvs_q   <= is_signed ? abs_val(div_if.rs2_data) : div_if.rs2_data;
         neg_q_q <= is_signed && (div_if.rs1_data[XLEN-1] ^ div_if.rs2_data[XLEN-1]);
         neg_r_q <= is_signed && div_if.rs1_data[XLEN-1];
         if (fast_path) begin
            result_q <= special_res;
            rd_out_q <= div_if.rd_addr;
         end
      end else if (state_q == CALC && !div_if.flush) begin
         rem_q <= step_rem;
         quo_q <= step_quo;
         cnt_q <= cnt_q + 1'b1;
         if (last_step) begin
            result_q <= final_res;
            rd_out_q <= rd_q;
         end
      end
   end

   assign div_if.stall       = start_ok || (state_q == CALC && !div_if.flush);
   assign div_if.done        = (state_q == DONE) && !div_if.flush;
   assign div_if.result      = result_q;
   assign div_if.rd_addr_out = rd_out_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// tb/tb_exe_div_unit.sv - randomized self-checking bench for exe_div_unit
module tb_exe_div_unit;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   exe_div_unit_if dif();

   exe_div_unit dut (
      .clk    (clk),
      .rst    (rst),
      .div_if (dif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit ref_signed(input logic [2:0] f3);
      return (f3 == 3'b100) || (f3 == 3'b110);
   endfunction

   function automatic bit ref_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return (b == 0) || (ref_signed(f3) && a == 32'h80000000 && b == 32'hFFFFFFFF);
   endfunction

   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
      bit rem;
      logic signed [31:0] sa, sb, sq, sr;
      rem = (f3 == 3'b110) || (f3 == 3'b111);
      if (b == 0)
         return rem ? a : 32'hFFFFFFFF;
      if (ref_signed(f3) && a == 32'h80000000 && b == 32'hFFFFFFFF)
         return rem ? 32'h0 : 32'h80000000;
      if (ref_signed(f3)) begin
         sa = $signed(a);
         sb = $signed(b);
         sq = sa / sb;
         sr = sa % sb;
         return rem ? sr : sq;
      end
      return rem ? (a % b) : (a / b);
   endfunction

   task automatic drive_idle();
      dif.start    = 1'b0;
      dif.flush    = 1'b0;
   endtask

   task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] rd);
      dif.start    = 1'b1;
      dif.flush    = 1'b0;
      dif.funct3   = f3;
      dif.rs1_data = a;
      dif.rs2_data = b;
      dif.rd_addr  = rd;
   endtask

   task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] rd);
      int lat, done_cyc, stall_cycles;
      lat = ref_fast(f3, a, b) ? 1 : 33;
      done_cyc = -1;
      stall_cycles = 0;
      @(negedge clk);
      drive_op(f3, a, b, rd);
      #1;
      check_eq({tag, "_stall_T"}, 32'(dif.stall), 32'd1);
      for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
         @(negedge clk);
         drive_idle();
         #1;
         if (dif.stall) stall_cycles++;
         if (dif.done) done_cyc = c;
      end
      check_eq({tag, "_latency"}, 32'(done_cyc), 32'(lat));
      check_eq({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(lat - 1));
      check_eq({tag, "_result"}, dif.result, ref_result(f3, a, b));
      check_eq({tag, "_rd"}, 32'(dif.rd_addr_out), 32'(rd));
   endtask

   initial begin
      int done_count;
      int done_at[$];
      logic [31:0] res_at[$];
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [5:0]  rd;
      int mode;

      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      dif.start = 1'b0;
      dif.flush = 1'b0;
      dif.funct3 = 3'b000;
      dif.rs1_data = '0;
      dif.rs2_data = '0;
      dif.rd_addr = '0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("reset_done", 32'(dif.done), 32'd0);
      check_eq("reset_stall", 32'(dif.stall), 32'd0);
      check_eq("reset_result", dif.result, 32'd0);
      check_eq("reset_rd", 32'(dif.rd_addr_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 6'd5);
      check_eq("divu_100_7_const", dif.result, 32'd14);
      do_op("div_m100_7", 3'b100, -32'd100, 32'd7, 6'd33);
      check_eq("div_m100_7_const", dif.result, 32'hFFFFFFF2);
      do_op("rem_m100_7", 3'b110, -32'd100, 32'd7, 6'd9);
      check_eq("rem_m100_7_const", dif.result, 32'hFFFFFFFE);
      do_op("remu_max_16", 3'b111, 32'hFFFFFFFF, 32'd16, 6'd1);
      check_eq("remu_max_16_const", dif.result, 32'd15);
      do_op("div_5_0", 3'b100, 32'd5, 32'd0, 6'd2);
      check_eq("div_5_0_const", dif.result, 32'hFFFFFFFF);
      do_op("rem_5_0", 3'b110, 32'd5, 32'd0, 6'd3);
      check_eq("rem_5_0_const", dif.result, 32'd5);
      do_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 6'd4);
      check_eq("div_ovf_const", dif.result, 32'h80000000);
      do_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 6'd6);
      check_eq("rem_ovf_const", dif.result, 32'd0);
      do_op("divu_ovf_ops", 3'b101, 32'h80000000, 32'hFFFFFFFF, 6'd7);
      do_op("f3_000_as_divu", 3'b000, 32'hF0000000, 32'd3, 6'd8);

      for (int i = 0; i < 40; i++) begin
         f3   = 3'($urandom_range(0, 7));
         a    = $urandom;
         b    = $urandom;
         rd   = 6'($urandom_range(0, 63));
         mode = $urandom_range(0, 7);
         if (mode == 0) b = 32'd0;
         else if (mode == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         else if (mode == 2) b = 32'($urandom_range(1, 15));
         else if (mode == 3) b = -32'($urandom_range(1, 15));
         do_op($sformatf("rand%0d", i), f3, a, b, rd);
      end

      // flush at T+10 of a running divide, then restart at T+11
      done_count = 0;
      @(negedge clk);
      drive_op(3'b101, 32'd1000, 32'd3, 6'd11);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         drive_idle();
         #1;
         if (dif.done) done_count++;
      end
      @(negedge clk);
      dif.flush = 1'b1;
      #1;
      check_eq("flush_stall", 32'(dif.stall), 32'd0);
      if (dif.done) done_count++;
      do_op("after_flush", 3'b101, 32'd1234567, 32'd89, 6'd12);
      check_eq("flush_no_done", 32'(done_count), 32'd0);

      // asynchronous reset in the middle of a signed divide
      done_count = 0;
      @(negedge clk);
      drive_op(3'b100, 32'd777, 32'd5, 6'd13);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         drive_idle();
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("midrst_stall", 32'(dif.stall), 32'd0);
      check_eq("midrst_done", 32'(dif.done), 32'd0);
      check_eq("midrst_result", dif.result, 32'd0);
      check_eq("midrst_rd", 32'(dif.rd_addr_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (dif.done) done_count++;
      end
      check_eq("midrst_no_done", 32'(done_count), 32'd0);

      // back-to-back divides: second start in the IDLE cycle after DONE
      for (int c = 0; c <= 72; c++) begin
         @(negedge clk);
         if (c == 0) drive_op(3'b101, 32'd5000, 32'd7, 6'd20);
         else if (c == 34) drive_op(3'b101, 32'hDEADBEEF, 32'd1000, 6'd21);
         else drive_idle();
         #1;
         if (dif.done) begin
            done_at.push_back(c);
            res_at.push_back(dif.result);
         end
      end
      check_eq("b2b_pulses", 32'(done_at.size()), 32'd2);
      if (done_at.size() == 2) begin
         check_eq("b2b_first_cyc", 32'(done_at[0]), 32'd33);
         check_eq("b2b_second_cyc", 32'(done_at[1]), 32'd67);
         check_eq("b2b_first_res", res_at[0], 32'd5000 / 32'd7);
         check_eq("b2b_second_res", res_at[1], 32'hDEADBEEF / 32'd1000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
